// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker instruction prefetch stage.
package tinker_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;
    localparam logic [PC_W-1:0] TINKER_RESET_PC = 64'h2000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } pf_state_t;

    // One queued fetch: the PC it was fetched from and the returned word.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/tinker_sync_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush; head is read combinationally.
module tinker_sync_fifo
    import tinker_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 push_data,
    output fetch_entry_t                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Flush shares the reset path: the whole queue is discarded at once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) slots[wr_ptr] <= push_data;
    end

    assign head_data = slots[rd_ptr];

endmodule

// File: rtl/tinker_prefetch_queue.sv
// Instruction prefetch: sequential fetch over a req/ack port into a small queue,
// with redirect flush and halt. At most one fetch is in flight and it always has a reserved slot.
module tinker_prefetch_queue
    import tinker_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = TINKER_RESET_PC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        redirect_valid,
    input  logic [PC_W-1:0]             redirect_pc,
    input  logic                        halt,
    output logic                        mem_req,
    output logic [PC_W-1:0]             mem_addr,
    input  logic                        mem_ack,
    input  logic [INSTR_W-1:0]          mem_rdata,
    output logic                        inst_valid,
    output logic [INSTR_W-1:0]          inst_data,
    output logic [PC_W-1:0]             inst_pc,
    input  logic                        inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]  q_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    pf_state_t        state;
    logic [PC_W-1:0]  fetch_pc;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_n;
    logic             has_space;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign inst_valid = (q_count != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign push       = (state == WAIT) && mem_ack && !redirect_valid;
    assign count_n    = q_count + CNT_W'(1) - CNT_W'(pop);
    assign has_space  = (q_count < CNT_W'(DEPTH));
    assign push_entry = '{pc: fetch_pc, instr: mem_rdata};
    assign inst_data  = head.instr;
    assign inst_pc    = head.pc;

    tinker_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head_data (head),
        .count     (q_count)
    );

    // Fetch FSM; redirect overrides ack, halt and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~PC_W'(3);
            case (state)
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state   <= DISCARD;
                    end
                end
                DISCARD: begin
                    // An ack arriving with the redirect still retires the stale request.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (!halt && has_space) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        fetch_pc <= fetch_pc + PC_W'(4);
                        if (!halt && count_n < CNT_W'(DEPTH)) begin
                            mem_addr <= fetch_pc + PC_W'(4);
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinker_prefetch_queue.sv
// Scoreboard bench: expected program-order PCs are queued by the driver, a monitor checks each consumed instruction.
module tb_tinker_prefetch_queue;
    import tinker_pkg::*;

    localparam logic [63:0] RST_PC = 64'h2000;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, halt, mem_req, mem_ack, inst_valid, inst_ready;
    logic [63:0] redirect_pc, mem_addr, inst_pc;
    logic [31:0] mem_rdata, inst_data;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    tinker_prefetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .q_count(q_count)
    );

    int          checks = 0;
    int          passed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_tail;
    int          lat_min = 0, lat_max = 0;
    bit          poison = 0;
    bit          redirect_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Instruction memory content: a fixed function of the address.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Program order restarts at the (word-aligned) target.
    task automatic restart(input logic [63:0] target);
        exp_q.delete();
        exp_tail = target & ~64'h3;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            while (exp_q.size() < 8) begin
                exp_q.push_back(exp_tail);
                exp_tail = exp_tail + 64'd4;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0; poison = 0;
        restart(RST_PC);
        tick();
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", mem_addr, RST_PC);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_q_count", 64'(q_count), 64'd0);
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        restart(target);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_until_req(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin tick(); n++; end
        if (!mem_req) check(name, 64'(mem_req), 64'd1);
    endtask

    // Memory responder: ack after lat_min..lat_max extra cycles, address must hold while waiting.
    initial begin
        int cnt = -1;
        logic [63:0] held_addr = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_req) begin
                mem_ack = 1'b0; cnt = -1;
            end else begin
                if (mem_ack || cnt < 0) cnt = int'($urandom_range(lat_max, lat_min));
                else check("mem_addr_stable", mem_addr, held_addr);
                held_addr = mem_addr;
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = poison ? 32'hDEAD_BEEF : word_at(mem_addr);
                    poison = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt--;
                end
            end
        end
    end

    // Monitor: every handshake must deliver the next PC in program order with its memory word.
    always @(negedge clk) begin
        if (redirect_seen && !reset) check("valid_after_redirect", 64'(inst_valid), 64'd0);
        redirect_seen = redirect_valid && !reset;
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_inst: got pc 0x%0h, expected nothing queued", inst_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst_data", 64'(inst_data), 64'(word_at(e)));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] tgt;
        int n;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = 1'b1;

        // Sequential fetch with single-cycle acks and a ready decoder.
        lat_min = 0; lat_max = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_mem_addr", mem_addr, RST_PC + 64'(4 * i));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_valid", 64'(inst_valid), 64'd1);
        end

        // Stalled decoder: exactly DEPTH fetches, then fetch resumes at the next PC.
        do_reset();
        inst_ready = 1'b0;
        tick(12);
        check("full_q_count", 64'(q_count), 64'd4);
        check("full_mem_req", 64'(mem_req), 64'd0);
        inst_ready = 1'b1;
        tick();
        wait_until_req("resume_req");
        check("resume_addr", mem_addr, 64'h2010);

        // Redirect while waiting: the late word is dropped.
        do_reset();
        lat_min = 3; lat_max = 3;
        tick();
        poison = 1;
        redirect(64'h3002);
        check("discard_addr_held", mem_addr, RST_PC);
        n = 0;
        while (poison && n < 10) begin tick(); n++; end
        tick();
        check("discard_idle_req", 64'(mem_req), 64'd0);
        tick();
        check("redir_req", 64'(mem_req), 64'd1);
        check("redir_addr", mem_addr, 64'h3000);
        n = 0;
        while (!inst_valid && n < 10) begin tick(); n++; end
        check("redir_first_pc", inst_pc, 64'h3000);

        // Redirect coincident with an ack and a pending pop.
        do_reset();
        lat_min = 1; lat_max = 1;
        inst_ready = 1'b0;
        tick(12);
        inst_ready = 1'b1;
        n = 0;
        while (!(mem_ack && mem_req && inst_valid) && n < 20) begin tick(); n++; end
        check("ack_pop_setup", 64'(mem_ack && inst_valid), 64'd1);
        tgt = {32'h0, $urandom} | 64'h1;
        redirect(tgt);
        check("ackredir_q_count", 64'(q_count), 64'd0);
        check("ackredir_valid", 64'(inst_valid), 64'd0);
        check("ackredir_req", 64'(mem_req), 64'd0);
        tick();
        check("ackredir_next_req", 64'(mem_req), 64'd1);
        check("ackredir_next_addr", mem_addr, tgt & ~64'h3);

        // Halt while a fetch is outstanding.
        do_reset();
        lat_min = 2; lat_max = 2;
        inst_ready = 1'b0;
        tick();
        check("halt_req_issued", 64'(mem_req), 64'd1);
        halt = 1'b1;
        n = 0;
        while (mem_req && n < 10) begin tick(); n++; end
        check("halt_q_count", 64'(q_count), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_no_req", 64'(mem_req), 64'd0);
        end
        halt = 1'b0;
        tick();
        check("unhalt_req", 64'(mem_req), 64'd1);
        check("unhalt_addr", mem_addr, 64'h2004);
        inst_ready = 1'b1;

        // Reset from WAIT with a part-full queue, then from DISCARD.
        do_reset();
        lat_min = 3; lat_max = 3;
        inst_ready = 1'b0;
        n = 0;
        while (!(q_count == 3'd3 && mem_req) && n < 40) begin tick(); n++; end
        check("wait_q3_setup", 64'(q_count), 64'd3);
        do_reset();
        n = 0;
        while (!(q_count == 3'd3 && mem_req) && n < 40) begin tick(); n++; end
        redirect(64'h5000);
        check("discard_req_held", 64'(mem_req), 64'd1);
        do_reset();
        inst_ready = 1'b1;

        // Randomized traffic, including redirects near the top of the address space.
        lat_min = 0; lat_max = 2;
        for (int c = 0; c < 3000; c++) begin
            inst_ready = ($urandom_range(9, 0) < 7);
            halt = ($urandom_range(19, 0) == 0);
            if ($urandom_range(299, 0) == 0) begin
                do_reset();
            end else if ($urandom_range(39, 0) == 0) begin
                if ($urandom_range(3, 0) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF6;
                else tgt = {$urandom, $urandom};
                redirect(tgt);
            end else begin
                tick();
            end
        end
        halt = 1'b0;
        inst_ready = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
